contador_param_ud: RTL and testbench

//  Parametrised up/down counter: generic width, range [FROM,TO], step size, prescaler and
//  end-of-range mode (wrap/saturate/one-shot). Adds sticky overflow and one-shot done flag.

---
 rtl/contador_pkg.sv | 33 +++
 rtl/contador_prescaler.sv | 48 ++++
 rtl/contador_param_ud.sv | 145 ++++++++++++++
 tb/tb_contador_param_ud.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// contador_pkg
//   Shared definitions for the counter family.
//   - MODE_* constants select the end-of-range behaviour.
//   - clamp_u64 / in_range_u64 are range helpers that other counter blocks reuse.
//     They work on 64-bit unsigned values, so callers zero-extend their operands
//     and truncate the result. Counters wider than 64 bits are not supported.
package contador_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  localparam int CNT_MAX_W = 64;

  // Returns 1 when lo <= v <= hi.
  function automatic logic in_range_u64(input logic [63:0] v,
                                        input logic [63:0] lo,
                                        input logic [63:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Forces v into [lo, hi].
  function automatic logic [63:0] clamp_u64(input logic [63:0] v,
                                            input logic [63:0] lo,
                                            input logic [63:0] hi);
    logic [63:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/contador_prescaler.sv
// contador_prescaler
//   Divides enabled cycles into count ticks. The module emits one tick every
//   PRESCALE enabled, non-cleared cycles.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset; the phase returns to 0
//     ena  - enable; when low, the phase holds
//     clr  - with ena, restarts the phase at 0 and suppresses the tick
//     tick - combinational; high on the last cycle of each prescale period
//   With PRESCALE=1 the module contains no register: tick = ena & !clr.
module contador_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  output logic tick
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("contador_prescaler: PRESCALE must be >= 1");
  end

  if (PRESCALE == 1) begin : g_direct
    // No phase to track; clk/rst are intentionally left unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign tick = ena & ~clr;
  end else begin : g_counted
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = ena & ~clr & (pre == LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        pre <= '0;
      end else if (ena) begin
        if (clr || (pre == LAST)) pre <= '0;
        else                      pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/contador_param_ud.sv
// contador_param_ud
//   Parametrised up/down counter with range [FROM,TO], a step size, a prescaler
//   and a selectable end-of-range mode (wrap / saturate / one-shot).
//   Parameters:
//     WIDTH    - counter width (1..64)
//     FROM     - lower bound, reset value and upward wrap target
//     TO       - upper bound, downward wrap target (FROM < TO)
//     STEP     - increment per tick (1 <= STEP <= TO-FROM)
//     MODE     - MODE_WRAP / MODE_SAT / MODE_ONESHOT
//     PRESCALE - enabled cycles per tick (>= 1)
//   Ports:
//     clk     - clock, rising edge
//     rst     - synchronous active-high reset, overrides everything
//     ena     - clock enable; all state holds when low
//     load    - with ena: cnt <= clamp(d), prescaler phase cleared, done cleared
//     up      - direction for the current tick (1 = +STEP, 0 = -STEP)
//     d       - load value
//     clr_ovf - clears ovf regardless of ena; a simultaneous boundary tick wins
//     tc      - terminal count (combinational), high in the cycle before the
//               wrap/saturate/stop edge
//     ovf     - sticky boundary-crossing flag
//     done    - one-shot finished (always 0 outside MODE_ONESHOT)
//     cnt     - current count
module contador_param_ud
  import contador_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] FROM     = '0,
  parameter logic [WIDTH-1:0] TO       = '1,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
  parameter int               MODE     = MODE_WRAP,
  parameter int               PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic             tc,
  output logic             ovf,
  output logic             done,
  output logic [WIDTH-1:0] cnt
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH:0] SPAN = {1'b0, TO} - {1'b0, FROM};

  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("contador_param_ud: WIDTH must be in 1..64");
  end
  if (!(FROM < TO)) begin : g_bad_range
    $error("contador_param_ud: FROM must be less than TO");
  end
  if (STEP == '0 || {1'b0, STEP} > SPAN) begin : g_bad_step
    $error("contador_param_ud: STEP must satisfy 1 <= STEP <= TO-FROM");
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT && MODE != MODE_ONESHOT) begin : g_bad_mode
    $error("contador_param_ud: MODE must be 0, 1 or 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("contador_param_ud: PRESCALE must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Prescaler: load acts as the phase clear, so a load never produces a tick.
  // ---------------------------------------------------------------------------
  logic tick;

  contador_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .clr  (load),
    .tick (tick)
  );

  // ---------------------------------------------------------------------------
  // Boundary detection. The distances to each bound are computed one bit wider
  // than the counter. cnt always stays inside [FROM,TO], so neither subtraction
  // can go negative.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] room_up;
  logic [WIDTH:0] room_down;
  logic           boundary;
  logic           live_tick;

  assign room_up   = {1'b0, TO}  - {1'b0, cnt};
  assign room_down = {1'b0, cnt} - {1'b0, FROM};
  assign boundary  = up ? (room_up < {1'b0, STEP}) : (room_down < {1'b0, STEP});

  // A finished one-shot ignores ticks entirely.
  assign live_tick = tick & ~done;
  assign tc        = live_tick & boundary;

  // ---------------------------------------------------------------------------
  // Load value clamping via the shared package helper
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] d_clamped;

  assign d_clamped = WIDTH'(clamp_u64(64'(d), 64'(FROM), 64'(TO)));

  // ---------------------------------------------------------------------------
  // Count, overflow and done registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= FROM;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      // The clear is placed first so that a boundary tick later in this block
      // overrides it in the same cycle.
      if (clr_ovf) ovf <= 1'b0;

      if (ena) begin
        if (load) begin
          cnt  <= d_clamped;
          done <= 1'b0;
        end else if (live_tick) begin
          if (boundary) begin
            ovf <= 1'b1;
            if (MODE == MODE_WRAP) begin
              // Any remainder of the step is discarded, not carried.
              cnt <= up ? FROM : TO;
            end else begin
              cnt <= up ? TO : FROM;
              if (MODE == MODE_ONESHOT) done <= 1'b1;
            end
          end else if (up) begin
            cnt <= cnt + STEP;
          end else begin
            cnt <= cnt - STEP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_contador_param_ud.sv
// tb_contador_param_ud
//   Directed bench for contador_param_ud. It uses WIDTH=8, FROM=10, TO=20 and STEP=3.
//   Four instances share clk/rst/load/up/d/clr_ovf. Each instance has its own
//   enable, so only the instance under test reacts:
//     u_wrap (MODE 0), u_sat (MODE 1), u_shot (MODE 2), u_pre (MODE 0, PRESCALE 4).
//   Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
//   unit after that, well away from the active edge.
`timescale 1ns/1ps
module tb_contador_param_ud;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       load;
  logic       up;
  logic [7:0] d;
  logic       clr_ovf;
  logic       ena_w, ena_s, ena_o, ena_p;

  logic       tc_w, ovf_w, done_w;
  logic       tc_s, ovf_s, done_s;
  logic       tc_o, ovf_o, done_o;
  logic       tc_p, ovf_p, done_p;
  logic [7:0] cnt_w, cnt_s, cnt_o, cnt_p;

  contador_param_ud #(.WIDTH(8), .FROM(8'd10), .TO(8'd20), .STEP(8'd3),
                      .MODE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .ena(ena_w), .load(load), .up(up), .d(d),
    .clr_ovf(clr_ovf), .tc(tc_w), .ovf(ovf_w), .done(done_w), .cnt(cnt_w));

  contador_param_ud #(.WIDTH(8), .FROM(8'd10), .TO(8'd20), .STEP(8'd3),
                      .MODE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .ena(ena_s), .load(load), .up(up), .d(d),
    .clr_ovf(clr_ovf), .tc(tc_s), .ovf(ovf_s), .done(done_s), .cnt(cnt_s));

  contador_param_ud #(.WIDTH(8), .FROM(8'd10), .TO(8'd20), .STEP(8'd3),
                      .MODE(2), .PRESCALE(1)) u_shot (
    .clk(clk), .rst(rst), .ena(ena_o), .load(load), .up(up), .d(d),
    .clr_ovf(clr_ovf), .tc(tc_o), .ovf(ovf_o), .done(done_o), .cnt(cnt_o));

  contador_param_ud #(.WIDTH(8), .FROM(8'd10), .TO(8'd20), .STEP(8'd3),
                      .MODE(0), .PRESCALE(4)) u_pre (
    .clk(clk), .rst(rst), .ena(ena_p), .load(load), .up(up), .d(d),
    .clr_ovf(clr_ovf), .tc(tc_p), .ovf(ovf_p), .done(done_p), .cnt(cnt_p));

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one clock; return 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Let combinational outputs settle after inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; clr_ovf = 1'b0; d = 8'd0;
    ena_w = 1'b0; ena_s = 1'b0; ena_o = 1'b0; ena_p = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; up = 1'b1;
    idle_inputs();
    step(2);
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_cnt_w",  cnt_w, 10);
    check("rst_ovf_w",  ovf_w, 0);
    check("rst_done_o", done_o, 0);
    check("rst_cnt_p",  cnt_p, 10);

    // ---- 1: wrap up / wrap down ----
    d = 8'd18; load = 1'b1; ena_w = 1'b1;
    step();
    check("w_load18", cnt_w, 18);
    load = 1'b0; up = 1'b1;
    settle();
    check("w_tc_at18", tc_w, 1);
    step();
    check("w_wrap_cnt", cnt_w, 10);
    check("w_wrap_ovf", ovf_w, 1);
    check("w_tc_at10_up", tc_w, 0);
    ena_w = 1'b0; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    settle();
    check("w_clr_ovf", ovf_w, 0);
    check("w_hold_no_ena", cnt_w, 10);
    up = 1'b0; ena_w = 1'b1;
    settle();
    check("w_tc_down10", tc_w, 1);
    step();
    check("w_wrap_down", cnt_w, 20);
    ena_w = 1'b0;

    // ---- 2: saturate down ----
    d = 8'd12; load = 1'b1; ena_s = 1'b1;
    step();
    check("s_load12", cnt_s, 12);
    load = 1'b0; up = 1'b0;
    settle();
    check("s_tc_at12", tc_s, 1);
    step();
    check("s_sat_cnt", cnt_s, 10);
    check("s_sat_ovf", ovf_s, 1);
    check("s_tc_held", tc_s, 1);
    step();
    check("s_hold10", cnt_s, 10);
    check("s_tc_again", tc_s, 1);
    check("s_done_tied0", done_s, 0);
    ena_s = 1'b0;

    // ---- 3: one-shot up ----
    up = 1'b1; ena_o = 1'b1;
    step();
    check("o_13", cnt_o, 13);
    step();
    check("o_16", cnt_o, 16);
    check("o_tc_at16", tc_o, 0);
    step();
    check("o_19", cnt_o, 19);
    check("o_tc_at19", tc_o, 1);
    step();
    check("o_20", cnt_o, 20);
    check("o_done", done_o, 1);
    check("o_tc_done", tc_o, 0);
    step();
    check("o_stay20", cnt_o, 20);
    d = 8'd15; load = 1'b1;
    step();
    load = 1'b0;
    settle();
    check("o_reload", cnt_o, 15);
    check("o_done_clr", done_o, 0);
    ena_o = 1'b0;

    // ---- 4: prescaler ----
    d = 8'd10; load = 1'b1; ena_p = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    step(3);
    check("p_before_tick", cnt_p, 10);
    step();
    check("p_tick1", cnt_p, 13);
    step();             // phase 1
    ena_p = 1'b0;
    step(2);            // phase held
    ena_p = 1'b1;
    step(2);            // phases 2, 3 (tick pending on the next edge)
    check("p_delayed_hold", cnt_p, 13);
    step();
    check("p_tick2", cnt_p, 16);
    step(2);            // phase 2
    d = 8'd10; load = 1'b1;
    step();
    load = 1'b0;
    check("p_load_cnt", cnt_p, 10);
    step(3);
    check("p_phase_reset", cnt_p, 10);
    step();
    check("p_tick_after_load", cnt_p, 13);
    ena_p = 1'b0;

    // ---- 5: load clamp / priority ----
    ena_w = 1'b1; load = 1'b1; d = 8'd250;
    step();
    check("l_clamp_hi", cnt_w, 20);
    d = 8'd3;
    step();
    check("l_clamp_lo", cnt_w, 10);
    ena_w = 1'b0; d = 8'd15;
    step();
    check("l_no_ena", cnt_w, 10);
    ena_w = 1'b1; d = 8'd15;
    step();
    check("l_load15", cnt_w, 15);
    d = 8'd17; rst = 1'b1;
    step();
    rst = 1'b0; load = 1'b0; ena_w = 1'b0;
    settle();
    check("l_rst_beats_load", cnt_w, 10);
    check("l_rst_ovf_sat", ovf_s, 0);

    // ---- 6: ovf race and reset mid-count ----
    ena_w = 1'b1; load = 1'b1; d = 8'd19;
    step();
    load = 1'b0; up = 1'b1; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0; ena_w = 1'b0;
    settle();
    check("r_ovf_set_wins", ovf_w, 1);
    check("r_wrap_cnt", cnt_w, 10);

    ena_p = 1'b1; up = 1'b1;
    step(6);            // phase 2, cnt 13
    check("r_pre_mid", cnt_p, 13);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("r_rst_cnt", cnt_p, 10);
    check("r_rst_ovf_w", ovf_w, 0);
    step(3);
    check("r_no_early_tick", cnt_p, 10);
    step();
    check("r_first_tick", cnt_p, 13);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
